// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side master for the synchronous FIFO (wr_en/din/rd_en/dout/prog_full).
//   Bursts of BURST_LEN reads are started by fifo_prog_full; words that sit in
//   the FIFO for TIMEOUT idle cycles without reaching prog_full are flushed one
//   at a time. Captured words are replayed on a valid/ready stream, with m_last
//   marking the final word of a burst and every flushed word.
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous reset, active-low
//   fifo_rd_en      FIFO read strobe (registered)
//   fifo_dout       FIFO read data, valid the cycle after fifo_rd_en
//   fifo_prog_full  FIFO programmable-full flag
//   fifo_empty      FIFO empty flag
//   m_valid/m_data/m_last/m_ready  output stream
//   busy            FSM active, output buffer occupied or a read in flight
//   stat_bursts     (READER_STAT_EN only) count of m_last handshakes, wraps
//
// Optional feature macro: READER_STAT_EN
module fifo_burst_reader #(
   parameter int WIDTH      = 32,
   parameter int BURST_LEN  = 8,
   parameter int TIMEOUT    = 64,
   parameter int OBUF_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_dout,
   input  logic             fifo_prog_full,
   input  logic             fifo_empty,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   input  logic             m_ready,
   output logic             busy
`ifdef READER_STAT_EN
   ,
   output logic [15:0]      stat_bursts
`endif
);

   localparam int AW = $clog2(OBUF_DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(BURST_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BURST, FLUSH, DRAIN} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [TW-1:0]    tmo, tmo_n;
   logic             issue, issue_last;
   logic             rd_last_p0;
   logic             vld_p1, last_p1;
   logic [PW-1:0]    wr_ptr, rd_ptr, occ;
   logic [PW:0]      pend;
   logic             empty, full, push, pop, credit;
   logic [WIDTH-1:0] data_mem [OBUF_DEPTH];
   logic             last_mem [OBUF_DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign occ   = wr_ptr - rd_ptr;

   // Reads already issued (rd_en high) or awaiting capture still need a slot,
   // so they are reserved against the buffer before another read is issued.
   assign pend   = {1'b0, occ} + {{PW{1'b0}}, fifo_rd_en} + {{PW{1'b0}}, vld_p1};
   assign credit = !fifo_empty && (pend < (PW+1)'(OBUF_DEPTH));

   assign push    = vld_p1 && !full;
   assign m_valid = !empty;
   assign pop     = m_valid && m_ready;
   // Gate with m_valid so the outputs read zero whenever nothing is held.
   assign m_data  = empty ? '0 : data_mem[rd_ptr[AW-1:0]];
   assign m_last  = empty ? 1'b0 : last_mem[rd_ptr[AW-1:0]];
   assign busy    = (state != IDLE) || !empty || fifo_rd_en || vld_p1;

   // The first read of a burst and the timeout flush read are issued on the
   // same edge that leaves IDLE, so a burst streams out two cycles after entry.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      tmo_n      = tmo;
      issue      = 1'b0;
      issue_last = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_prog_full) begin
               tmo_n   = '0;
               state_n = BURST;
               cnt_n   = CW'(BURST_LEN);
               if (credit) begin
                  issue = 1'b1;
                  cnt_n = CW'(BURST_LEN - 1);
                  if (BURST_LEN == 1) begin
                     issue_last = 1'b1;
                     state_n    = DRAIN;
                  end
               end
            end else if (!fifo_empty) begin
               if (tmo == TW'(TIMEOUT - 1)) begin
                  tmo_n   = '0;
                  state_n = FLUSH;
                  if (credit) begin
                     issue      = 1'b1;
                     issue_last = 1'b1;
                     state_n    = DRAIN;
                  end
               end else begin
                  tmo_n = tmo + 1'b1;
               end
            end else begin
               tmo_n = '0;
            end
         end
         BURST: begin
            // An empty FIFO mid-burst only withholds credit; the burst stays open.
            if (credit) begin
               issue = 1'b1;
               cnt_n = cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  issue_last = 1'b1;
                  state_n    = DRAIN;
               end
            end
         end
         FLUSH: begin
            if (credit) begin
               issue      = 1'b1;
               issue_last = 1'b1;
               state_n    = DRAIN;
            end
         end
         DRAIN: begin
            if (!fifo_rd_en && !vld_p1) begin
               state_n = IDLE;
               tmo_n   = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         tmo        <= '0;
         fifo_rd_en <= 1'b0;
         rd_last_p0 <= 1'b0;
         vld_p1     <= 1'b0;
         last_p1    <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         tmo        <= tmo_n;
         // stage p0: read strobe and its last tag leave the FSM
         fifo_rd_en <= issue;
         rd_last_p0 <= issue_last;
         // stage p1: fifo_dout is valid this cycle, captured at its end
         vld_p1     <= fifo_rd_en;
         last_p1    <= rd_last_p0;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr[AW-1:0]] <= fifo_dout;
         last_mem[wr_ptr[AW-1:0]] <= last_p1;
      end
   end

`ifdef READER_STAT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              stat_bursts <= '0;
      else if (pop && m_last) stat_bursts <= stat_bursts + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader
//   Scoreboard bench: a behavioural FIFO feeds the reader; each scenario
//   predicts the output words from the FIFO contents (a burst takes the next
//   BURST_LEN words with last on the final one; a flush emits one word with
//   last) and a monitor pops and compares on every output handshake.
module tb_fifo_burst_reader;

   localparam int WIDTH      = 32;
   localparam int BURST_LEN  = 8;
   localparam int TIMEOUT    = 64;
   localparam int OBUF_DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             fifo_rd_en;
   logic [WIDTH-1:0] fifo_dout;
   logic             fifo_prog_full;
   logic             fifo_empty;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_last;
   logic             m_ready;
   logic             busy;
`ifdef READER_STAT_EN
   logic [15:0]      stat_bursts;
`endif

   always #5 clk = ~clk;

   fifo_burst_reader #(
      .WIDTH(WIDTH), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT), .OBUF_DEPTH(OBUF_DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
      .fifo_prog_full(fifo_prog_full), .fifo_empty(fifo_empty),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
      .busy(busy)
`ifdef READER_STAT_EN
      , .stat_bursts(stat_bursts)
`endif
   );

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   logic [WIDTH-1:0] fifo_q [$];
   logic [WIDTH:0]   exp_q  [$];
   int rd_cnt, rd_first, rd_last, mv_first, busy_fall, t0;
   int exp_lasts;
   logic rnd_ready   = 1'b0;
   logic ready_force = 1'b1;
   logic [WIDTH-1:0] w0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Behavioural FIFO: read data appears the cycle after rd_en.
   initial begin
      fifo_empty = 1'b1;
      fifo_dout  = '0;
      forever begin
         @(posedge clk);
         if (fifo_rd_en) begin
            checks++;
            if (fifo_q.size() == 0) begin
               fails++;
               $display("FAIL fifo_underflow: rd_en with empty FIFO (cycle %0d)", cyc);
            end else begin
               fifo_dout <= fifo_q.pop_front();
            end
         end
         fifo_empty <= (fifo_q.size() == 0);
      end
   end

   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         m_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_force;
      end
   end

   // Monitor / scoreboard
   logic             prev_v, prev_r, prev_l, prev_busy;
   logic [WIDTH-1:0] prev_d;
   logic [WIDTH:0]   e;
   initial begin
      prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = '0; prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (fifo_rd_en) begin
               rd_cnt++;
               if (rd_first < 0) rd_first = cyc;
               rd_last = cyc;
            end
            if (m_valid && mv_first < 0) mv_first = cyc;
            if (!fifo_empty && t0 < 0) t0 = cyc;
            if (prev_busy && !busy) busy_fall = cyc;
            if (prev_v && !prev_r) begin
               chk("hold_valid", 64'(m_valid), 64'd1);
               chk("hold_word", 64'({m_last, m_data}), 64'({prev_l, prev_d}));
            end
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL unexpected_word: got last=%0d data=0x%0h, expected none", m_last, m_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_word", 64'({m_last, m_data}), 64'(e));
               end
            end
            prev_v = m_valid; prev_r = m_ready; prev_d = m_data; prev_l = m_last;
            prev_busy = busy;
         end else begin
            prev_v = 1'b0;
            prev_busy = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_stats();
      rd_cnt = 0; rd_first = -1; rd_last = -1; mv_first = -1; busy_fall = -1; t0 = -1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      fifo_prog_full = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      exp_lasts = 0;
      repeat (2) tick();
      clr_stats();
      rst = 1'b1;
      tick();
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(WIDTH'($urandom));
   endtask

   task automatic expect_burst();
      for (int i = 0; i < BURST_LEN; i++) exp_q.push_back({(i == BURST_LEN - 1), fifo_q[i]});
      exp_lasts++;
   endtask

   task automatic pulse_pf();
      fifo_prog_full = 1'b1;
      tick();
      fifo_prog_full = 1'b0;
   endtask

   task automatic wait_empty(input int budget, input string name);
      int k;
      for (k = 0; k < budget; k++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      chk({name, "_wait_out"}, 64'(k < budget), 64'd1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k;
      for (k = 0; k < budget; k++) begin
         if (exp_q.size() == 0 && !busy) break;
         tick();
      end
      chk({name, "_wait_idle"}, 64'(k < budget), 64'd1);
   endtask

   task automatic stat_chk(input string name);
`ifdef READER_STAT_EN
      chk({name, "_stat_bursts"}, 64'(stat_bursts), 64'(16'(exp_lasts)));
`else
      if (name.len() < 0) $display("%s", name);
`endif
   endtask

   initial begin
      int k;
      int n;
      rst = 1'b0;
      fifo_prog_full = 1'b0;
      exp_lasts = 0;
      clr_stats();
      repeat (3) tick();
      chk("rst_rd_en",  64'(fifo_rd_en), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_last", 64'(m_last), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      chk("rst_busy",   64'(busy), 64'd0);
`ifdef READER_STAT_EN
      chk("rst_stat",   64'(stat_bursts), 64'd0);
`endif
      rst = 1'b1;
      tick();

      // Burst with no backpressure: words 1..10 preloaded
      for (int i = 1; i <= 10; i++) fifo_q.push_back(WIDTH'(i));
      tick();
      expect_burst();
      pulse_pf();
      wait_empty(200, "burst");
      chk("burst_busy_after_last", 64'(busy), 64'd0);
      chk("burst_rd_count", 64'(rd_cnt), 64'd8);
      chk("burst_rd_consecutive", 64'(rd_last - rd_first), 64'd7);
      chk("burst_first_valid_latency", 64'(mv_first - rd_first), 64'd2);
      stat_chk("burst");
      do_reset();

      // Backpressure: m_ready low for 10 cycles
      push_words(10);
      w0 = fifo_q[0];
      ready_force = 1'b0;
      tick();
      expect_burst();
      pulse_pf();
      repeat (10) tick();
      chk("bp_rd_count_le4", 64'(rd_cnt <= 4), 64'd1);
      chk("bp_valid_held", 64'(m_valid), 64'd1);
      chk("bp_data_held", 64'(m_data), 64'(w0));
      ready_force = 1'b1;
      wait_empty(200, "bp");
      wait_idle(50, "bp");
      chk("bp_rd_count", 64'(rd_cnt), 64'd8);
      stat_chk("bp");
      do_reset();

      // Timeout flush of two residual words
      push_words(2);
      exp_q.push_back({1'b1, fifo_q[0]});
      exp_q.push_back({1'b1, fifo_q[1]});
      exp_lasts += 2;
      for (k = 0; k < 400; k++) begin
         if (rd_cnt >= 2) break;
         tick();
      end
      chk("tmo_two_reads", 64'(k < 400), 64'd1);
      chk("tmo_first_read_cycle", 64'(rd_first - t0), 64'(TIMEOUT));
      chk("tmo_second_read_cycle", 64'(rd_last - busy_fall), 64'(TIMEOUT));
      wait_idle(100, "tmo");
      stat_chk("tmo");
      do_reset();

      // prog_full arrives in the cycle the timeout counter reaches TIMEOUT-1
      push_words(12);
      expect_burst();
      repeat (TIMEOUT) @(posedge clk);
      #1;
      fifo_prog_full = 1'b1;
      tick();
      fifo_prog_full = 1'b0;
      wait_empty(200, "prio");
      chk("prio_first_read_cycle", 64'(rd_first - t0), 64'(TIMEOUT));
      chk("prio_rd_count", 64'(rd_cnt), 64'd8);
      wait_idle(50, "prio");
      stat_chk("prio");
      do_reset();

      // Reset in the middle of a burst
      push_words(16);
      tick();
      expect_burst();
      pulse_pf();
      for (k = 0; k < 50; k++) begin
         if (rd_cnt >= 3) break;
         tick();
      end
      chk("mid_three_reads", 64'(k < 50), 64'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_rd_en",  64'(fifo_rd_en), 64'd0);
      chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
      chk("mid_rst_m_last", 64'(m_last), 64'd0);
      chk("mid_rst_m_data", 64'(m_data), 64'd0);
      chk("mid_rst_busy",   64'(busy), 64'd0);
      exp_q.delete();
      exp_lasts = 0;
      repeat (2) tick();
      clr_stats();
      rst = 1'b1;
      repeat (3) tick();
      chk("mid_no_stale_valid", 64'(m_valid), 64'd0);
      expect_burst();
      pulse_pf();
      wait_empty(200, "mid");
      wait_idle(50, "mid");
      chk("mid_rd_count", 64'(rd_cnt), 64'd8);
      stat_chk("mid");
      do_reset();

      // Randomized rounds: burst plus residual flushes under random backpressure
      rnd_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         n = BURST_LEN + int'($urandom_range(0, 3));
         push_words(n);
         tick();
         expect_burst();
         for (int i = BURST_LEN; i < n; i++) exp_q.push_back({1'b1, fifo_q[i]});
         exp_lasts += n - BURST_LEN;
         pulse_pf();
         wait_idle(1500, "rand");
         chk("rand_fifo_drained", 64'(fifo_q.size()), 64'd0);
         stat_chk("rand");
      end
      rnd_ready = 1'b0;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
